// File: rtl/prbs_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions for the serial checker and the future generator.
package prbs_pkg;

    localparam int unsigned PRBS7_W     = 7;
    localparam int unsigned PRBS7_TAP_A = 6;
    localparam int unsigned PRBS7_TAP_B = 5;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } chk_state_e;

    typedef struct packed {
        logic [PRBS7_W-1:0] lfsr;
        logic               pred;
    } prbs7_step_t;

    // One PRBS7 step: predicted bit and the register after shifting it in.
    function automatic prbs7_step_t prbs7_next(input logic [PRBS7_W-1:0] lfsr);
        prbs7_step_t s;
        s.pred = lfsr[PRBS7_TAP_A] ^ lfsr[PRBS7_TAP_B];
        s.lfsr = {lfsr[PRBS7_W-2:0], s.pred};
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/serial_prbs_checker.sv
// Self-synchronising PRBS7 checker: seeds from the stream, verifies, then checks every valid bit
// against a free-running LFSR so that line errors never corrupt the reference.
module serial_prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned SEED_W  = 3;
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW + 1);
    localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

    chk_state_e          state_q, state_d;
    logic [PRBS7_W-1:0]  lfsr_q, lfsr_d;
    logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]   win_errs_q, win_errs_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    prbs7_step_t         step_c;
    logic [MATCH_W-1:0]  match_nxt_c;
    logic [WIN_W-1:0]    win_cnt_nxt_c;
    logic [WERR_W-1:0]   win_errs_nxt_c;
    logic                err_inc_c;
    logic                bit_inc_c;

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        seed_cnt_d     = seed_cnt_q;
        match_cnt_d    = match_cnt_q;
        win_cnt_d      = win_cnt_q;
        win_errs_d     = win_errs_q;
        err_d          = 1'b0;
        err_inc_c      = 1'b0;
        bit_inc_c      = 1'b0;
        step_c         = prbs7_next(lfsr_q);
        match_nxt_c    = match_cnt_q + MATCH_W'(1);
        win_cnt_nxt_c  = win_cnt_q + WIN_W'(1);
        win_errs_nxt_c = win_errs_q;

        if (en) begin
            unique case (state_q)
                SEED: begin
                    lfsr_d = {lfsr_q[PRBS7_W-2:0], in};
                    if (seed_cnt_q == SEED_W'(PRBS7_W - 1)) begin
                        seed_cnt_d = '0;
                        // An all-zero seed is the LFSR lock-up state; collect a fresh one.
                        if (lfsr_d != '0) begin
                            state_d     = VERIFY;
                            match_cnt_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end
                VERIFY: begin
                    if (in == step_c.pred) begin
                        lfsr_d      = step_c.lfsr;
                        match_cnt_d = match_nxt_c;
                        if (match_nxt_c == MATCH_W'(LOCK_COUNT)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            win_cnt_d   = '0;
                            win_errs_d  = '0;
                        end
                    end else begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    lfsr_d    = step_c.lfsr;
                    bit_inc_c = 1'b1;
                    if (in != step_c.pred) begin
                        err_d          = 1'b1;
                        err_inc_c      = 1'b1;
                        win_errs_nxt_c = win_errs_q + WERR_W'(1);
                    end
                    win_cnt_d  = win_cnt_nxt_c;
                    win_errs_d = win_errs_nxt_c;
                    // Unlock takes precedence; otherwise a full window restarts both counters.
                    if (win_errs_nxt_c == WERR_W'(UNLOCK_ERRS)) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end else if (win_cnt_nxt_c == WIN_W'(WINDOW)) begin
                        win_cnt_d  = '0;
                        win_errs_d = '0;
                    end
                end
                default: begin
                    state_d    = SEED;
                    seed_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEED;
            lfsr_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_errs_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_errs_q  <= win_errs_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_count (
        .clk   (clk),
        .rst_n (rst),
        .inc   (err_inc_c),
        .clr   (clear),
        .count (err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_count (
        .clk   (clk),
        .rst_n (rst),
        .inc   (bit_inc_c),
        .clr   (clear),
        .count (bit_count)
    );

    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_serial_prbs_checker.sv
// Directed bench for serial_prbs_checker: vector table over a long stream plus hand-written corner sequences.
module tb_serial_prbs_checker;

    logic        clk;
    logic        rst;
    logic        din;
    logic        en;
    logic        clear;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    int n_checks;
    int n_fail;

    logic [6:0] gen;
    int         gen_n;

    typedef struct {
        logic en;
        logic flip;
        logic clr;
        logic exp_locked;
        logic exp_err;
        int   exp_errc;
        int   exp_bitc;
    } vec_t;

    vec_t vecs[$];

    serial_prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .en        (en),
        .clear     (clear),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference stream: seven ones (seed 7'h7F), then x^7 + x^6 + 1 continuation.
    task automatic gen_bit(output logic b);
        if (gen_n < 7) b = 1'b1;
        else           b = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
        gen_n++;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        din   = 1'b0;
        gen   = '0;
        gen_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic step(input logic v_en, input logic flip, input logic v_clr);
        logic b;
        if (v_en) begin
            gen_bit(b);
            din = b ^ flip;
        end else begin
            din = 1'($urandom);
        end
        en    = v_en;
        clear = v_clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        do_reset();
        check("reset locked", 32'(locked), 0);
        check("reset err", 32'(err), 0);
        check("reset err_count", 32'(err_count), 0);
        check("reset bit_count", 32'(bit_count), 0);

        // Stream of 122 valid bits: lock, single error, clear, window-boundary error, unlock, relock, clear+error.
        for (int k = 1; k <= 122; k++) begin
            v.en   = 1'b1;
            v.flip = (k == 31) || (k == 87) || (k >= 88 && k <= 95) || (k == 121);
            v.clr  = (k == 60) || (k == 121);
            v.exp_locked = ((k >= 23) && (k <= 94)) || (k >= 118);
            v.exp_err    = v.flip;
            if (k < 31)       v.exp_errc = 0;
            else if (k < 60)  v.exp_errc = 1;
            else if (k < 87)  v.exp_errc = 0;
            else if (k == 87) v.exp_errc = 1;
            else if (k <= 95) v.exp_errc = k - 86;
            else if (k <= 120) v.exp_errc = 9;
            else              v.exp_errc = 0;
            if (k <= 23)       v.exp_bitc = 0;
            else if (k < 60)   v.exp_bitc = k - 23;
            else if (k <= 95)  v.exp_bitc = k - 60;
            else if (k <= 118) v.exp_bitc = 35;
            else if (k <= 120) v.exp_bitc = k - 83;
            else if (k == 121) v.exp_bitc = 0;
            else               v.exp_bitc = 1;
            vecs.push_back(v);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].flip, vecs[i].clr);
            check($sformatf("vec%0d locked", i + 1), 32'(locked), 32'(vecs[i].exp_locked));
            check($sformatf("vec%0d err", i + 1), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d err_count", i + 1), 32'(err_count), 32'(vecs[i].exp_errc));
            check($sformatf("vec%0d bit_count", i + 1), 32'(bit_count), 32'(vecs[i].exp_bitc));
        end

        // Constant-zero stream never seeds a nonzero LFSR.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            en    = 1'b1;
            din   = 1'b0;
            clear = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("zeros%0d locked", i), 32'(locked), 0);
            check($sformatf("zeros%0d err", i), 32'(err), 0);
        end

        // Every other cycle idle with garbage on the line; lock depends on valid bits only.
        do_reset();
        for (int vb = 1; vb <= 30; vb++) begin
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("idle%0d locked", vb), 32'(locked), 32'((vb - 1) >= 23));
            check($sformatf("idle%0d err", vb), 32'(err), 0);
            check($sformatf("idle%0d bit_count", vb), 32'(bit_count), 32'((vb - 1) >= 24 ? vb - 24 : 0));
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("valid%0d locked", vb), 32'(locked), 32'(vb >= 23));
            check($sformatf("valid%0d err", vb), 32'(err), 0);
            check($sformatf("valid%0d bit_count", vb), 32'(bit_count), 32'(vb >= 24 ? vb - 23 : 0));
        end

        // Asynchronous reset between edges while locked.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async rst locked", 32'(locked), 0);
        check("async rst err", 32'(err), 0);
        check("async rst err_count", 32'(err_count), 0);
        check("async rst bit_count", 32'(bit_count), 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
